// File: rtl/classificador_pkg.sv
// Shared types and material helpers for the item sorter.
// Both the top-level FSM and the bench-facing debug state use these.
package classificador_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DETECT     = 3'd1,
        CLASSIFY   = 3'd2,
        ACTUATE    = 3'd3,
        WAIT_CLEAR = 3'd4,
        ERRO       = 3'd5
    } estado_t;

    localparam logic [1:0] MAT_DESCONHECIDO = 2'b00;
    localparam logic [1:0] MAT_PLASTICO     = 2'b01;
    localparam logic [1:0] MAT_METAL        = 2'b10;
    localparam logic [1:0] MAT_ORGANICO     = 2'b11;

    // Unknown material is treated as non-recyclable.
    function automatic logic eh_reciclavel(input logic [1:0] code);
        return (code == MAT_PLASTICO) || (code == MAT_METAL);
    endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Saturating up-counter used for debounce, gate hold and jam timeout.
// fim is high on the enabled cycle whose edge brings the count to LIMIT.
module contador_ciclos #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic restart,
    input  logic en,
    output logic fim
);

    localparam int unsigned W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (en && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign fim = en && !restart && (count_q == LAST);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/classificador_residuos.sv
// Item sorter: debounces presence, classifies material once per item,
// pulses the matching counter, holds the diverter gate and flags jams.
module classificador_residuos
    import classificador_pkg::*;
#(
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned GATE_CYCLES = 8,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       sensor_presenca,
    input  logic [1:0] sensor_material,
    output logic       pulso_reciclavel,
    output logic       pulso_nao_reciclavel,
    output logic       comporta,
    output logic       ocupado,
    output logic       erro,
    output logic [2:0] estado_dbg
);

    estado_t state_q, state_d;
    logic    pr_q, pr_d;
    logic    pn_q, pn_d;
    logic    comp_q, comp_d;
    logic    ocup_q, ocup_d;
    logic    erro_q, erro_d;

    logic deb_rst, deb_en, deb_fim;
    logic gate_rst, gate_en, gate_fim;
    logic to_rst, to_en, to_fim;

    contador_ciclos #(.LIMIT(DEBOUNCE)) u_debounce (
        .clock(clock), .clear(clear), .restart(deb_rst), .en(deb_en), .fim(deb_fim)
    );

    contador_ciclos #(.LIMIT(GATE_CYCLES)) u_gate (
        .clock(clock), .clear(clear), .restart(gate_rst), .en(gate_en), .fim(gate_fim)
    );

    contador_ciclos #(.LIMIT(TIMEOUT)) u_timeout (
        .clock(clock), .clear(clear), .restart(to_rst), .en(to_en), .fim(to_fim)
    );

    always_comb begin
        state_d  = state_q;
        pr_d     = 1'b0;
        pn_d     = 1'b0;
        comp_d   = comp_q;
        erro_d   = erro_q;
        deb_rst  = 1'b1;
        deb_en   = 1'b0;
        gate_rst = 1'b1;
        gate_en  = 1'b0;
        to_rst   = 1'b1;
        to_en    = 1'b0;
        case (state_q)
            IDLE: begin
                comp_d  = 1'b0;
                deb_rst = !sensor_presenca;
                deb_en  = sensor_presenca;
                if (sensor_presenca) state_d = DETECT;
            end
            DETECT: begin
                deb_rst = !sensor_presenca;
                deb_en  = sensor_presenca;
                if (!sensor_presenca) state_d = IDLE;
                else if (deb_fim)     state_d = CLASSIFY;
            end
            CLASSIFY: begin
                // The only cycle in which the material code matters.
                if (eh_reciclavel(sensor_material)) begin
                    pr_d   = 1'b1;
                    comp_d = 1'b1;
                end else begin
                    pn_d   = 1'b1;
                    comp_d = 1'b0;
                end
                state_d = ACTUATE;
            end
            ACTUATE: begin
                gate_rst = 1'b0;
                gate_en  = 1'b1;
                if (gate_fim) begin
                    comp_d  = 1'b0;
                    state_d = WAIT_CLEAR;
                end
            end
            WAIT_CLEAR: begin
                comp_d = 1'b0;
                to_rst = !sensor_presenca;
                to_en  = sensor_presenca;
                if (!sensor_presenca) begin
                    state_d = IDLE;
                end else if (to_fim) begin
                    erro_d  = 1'b1;
                    state_d = ERRO;
                end
            end
            ERRO: begin
                comp_d = 1'b0;
                erro_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ocup_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            pr_q    <= 1'b0;
            pn_q    <= 1'b0;
            comp_q  <= 1'b0;
            ocup_q  <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            pn_q    <= pn_d;
            comp_q  <= comp_d;
            ocup_q  <= ocup_d;
            erro_q  <= erro_d;
        end
    end

    assign pulso_reciclavel     = pr_q;
    assign pulso_nao_reciclavel = pn_q;
    assign comporta             = comp_q;
    assign ocupado              = ocup_q;
    assign erro                 = erro_q;
    assign estado_dbg           = state_q;

endmodule

// File: tb/tb_classificador_residuos.sv
// Directed bench for classificador_residuos: an edge-count model of the sorter
// checked every cycle, plus literal expectations per scenario.
module tb_classificador_residuos;

    localparam int DEBOUNCE    = 4;
    localparam int GATE_CYCLES = 8;
    localparam int TIMEOUT     = 32;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       sensor_presenca = 1'b0;
    logic [1:0] sensor_material = 2'b00;
    logic       pulso_reciclavel;
    logic       pulso_nao_reciclavel;
    logic       comporta;
    logic       ocupado;
    logic       erro;
    logic [2:0] estado_dbg;

    int vectors = 0;
    int errors  = 0;

    classificador_residuos #(
        .DEBOUNCE(DEBOUNCE), .GATE_CYCLES(GATE_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .clear(clear),
        .sensor_presenca(sensor_presenca),
        .sensor_material(sensor_material),
        .pulso_reciclavel(pulso_reciclavel),
        .pulso_nao_reciclavel(pulso_nao_reciclavel),
        .comporta(comporta),
        .ocupado(ocupado),
        .erro(erro),
        .estado_dbg(estado_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    // Behavioural model: edge number n since reset release; an item is
    // accepted at edge acc once DEBOUNCE consecutive high samples are seen.
    int n = 0;
    int acc = -1;
    int run = 0;
    int wait_run = 0;
    bit rec = 1'b0;
    bit jam = 1'b0;
    bit m_pr = 1'b0, m_pn = 1'b0, m_comp = 1'b0, m_ocup = 1'b0, m_erro = 1'b0;

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            n = 0; acc = -1; run = 0; wait_run = 0; rec = 1'b0; jam = 1'b0;
            m_pr = 1'b0; m_pn = 1'b0; m_comp = 1'b0; m_ocup = 1'b0; m_erro = 1'b0;
        end else begin
            n = n + 1;
            m_pr = 1'b0;
            m_pn = 1'b0;
            if (jam) begin
                // stuck until clear
            end else if (acc < 0) begin
                run = sensor_presenca ? run + 1 : 0;
                if (run == DEBOUNCE) begin
                    acc = n;
                    run = 0;
                    wait_run = 0;
                end
            end else if (n == acc + 1) begin
                rec  = (sensor_material == 2'b01) || (sensor_material == 2'b10);
                m_pr = rec;
                m_pn = !rec;
            end else if (n > acc + 1 + GATE_CYCLES) begin
                if (!sensor_presenca) begin
                    acc = -1;
                    wait_run = 0;
                end else begin
                    wait_run = wait_run + 1;
                    if (wait_run == TIMEOUT) jam = 1'b1;
                end
            end
            m_comp = !jam && (acc >= 0) && (n >= acc + 1) && (n < acc + 1 + GATE_CYCLES) && rec;
            m_ocup = jam || (acc >= 0) || (run > 0);
            m_erro = jam;
        end
    end

    // Scoreboard compare plus running observation counters
    int n_pr = 0, n_pn = 0, n_comp = 0;
    int pr_edge = -1, pn_edge = -1, erro_edge = -1;
    logic erro_prev = 1'b0;

    always @(negedge clock) begin
        vectors = vectors + 1;
        if ({pulso_reciclavel, pulso_nao_reciclavel, comporta, ocupado, erro} !==
            {m_pr, m_pn, m_comp, m_ocup, m_erro}) begin
            errors = errors + 1;
            $display("FAIL outputs edge %0d: got pr=%b pn=%b comp=%b ocup=%b erro=%b expected pr=%b pn=%b comp=%b ocup=%b erro=%b",
                     n, pulso_reciclavel, pulso_nao_reciclavel, comporta, ocupado, erro,
                     m_pr, m_pn, m_comp, m_ocup, m_erro);
        end
        if (pulso_reciclavel)     begin n_pr = n_pr + 1; pr_edge = n; end
        if (pulso_nao_reciclavel) begin n_pn = n_pn + 1; pn_edge = n; end
        if (comporta)             n_comp = n_comp + 1;
        if (erro && !erro_prev)   erro_edge = n;
        erro_prev = erro;
    end

    task automatic check(input string name, input int got, input int exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after a falling edge
    task automatic step(input logic p, input logic [1:0] m, input int k);
        sensor_presenca = p;
        sensor_material = m;
        repeat (k) @(negedge clock);
        #1;
    endtask

    task automatic apply_clear(input int k);
        clear = 1'b1;
        repeat (k) @(negedge clock);
        #1;
        clear = 1'b0;
    endtask

    int b_pr, b_pn, b_comp;

    task automatic snap();
        b_pr = n_pr; b_pn = n_pn; b_comp = n_comp;
    endtask

    initial begin
        @(negedge clock);
        #1;

        // Reset with item already present, then plastic item
        sensor_presenca = 1'b1;
        sensor_material = 2'b01;
        apply_clear(2);
        check("reset_outputs_zero", {pulso_reciclavel, pulso_nao_reciclavel, comporta, ocupado, erro}, 0);
        snap();
        step(1'b1, 2'b01, 20);
        check("plastic_pr_count", n_pr - b_pr, 1);
        check("plastic_pr_edge", pr_edge, 5);
        check("plastic_comp_cycles", n_comp - b_comp, 8);
        check("plastic_pn_count", n_pn - b_pn, 0);
        check("plastic_erro", erro, 0);
        step(1'b0, 2'b01, 3);

        // Bounce rejection
        apply_clear(1);
        snap();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'b01, 3);
            step(1'b0, 2'b01, 1);
        end
        step(1'b0, 2'b01, 3);
        check("bounce_pulses", (n_pr - b_pr) + (n_pn - b_pn), 0);
        check("bounce_ocupado", ocupado, 0);

        // Organic then unknown; material changed mid-gate must be ignored
        apply_clear(1);
        snap();
        step(1'b1, 2'b11, 5);
        step(1'b0, 2'b01, 12);
        step(1'b1, 2'b00, 5);
        step(1'b0, 2'b00, 14);
        check("org_unk_pn_count", n_pn - b_pn, 2);
        check("org_unk_pn_edge", pn_edge, 22);
        check("org_unk_pr_count", n_pr - b_pr, 0);
        check("org_unk_comp_cycles", n_comp - b_comp, 0);

        // Metal: only the code present at the classify edge counts
        apply_clear(1);
        snap();
        step(1'b1, 2'b11, 4);
        step(1'b1, 2'b10, 1);
        step(1'b0, 2'b11, 12);
        check("metal_pr_count", n_pr - b_pr, 1);
        check("metal_pn_count", n_pn - b_pn, 0);
        check("metal_comp_cycles", n_comp - b_comp, 8);

        // Back-to-back items at the minimum period of 14 cycles
        apply_clear(1);
        snap();
        step(1'b1, 2'b10, 13);
        step(1'b0, 2'b10, 1);
        step(1'b1, 2'b11, 13);
        step(1'b0, 2'b11, 3);
        check("b2b_pr_count", n_pr - b_pr, 1);
        check("b2b_pn_count", n_pn - b_pn, 1);
        check("b2b_pn_edge", pn_edge, 19);

        // Jam: presence held for 60 cycles
        apply_clear(1);
        snap();
        step(1'b1, 2'b01, 60);
        check("jam_pr_count", n_pr - b_pr, 1);
        check("jam_erro_edge", erro_edge, 45);
        step(1'b0, 2'b01, 5);
        check("jam_erro_sticky", erro, 1);
        check("jam_ocupado", ocupado, 1);

        // Mid-operation clear during ACTUATE
        apply_clear(1);
        step(1'b1, 2'b01, 7);
        check("midrst_comp_before", comporta, 1);
        check("midrst_ocup_before", ocupado, 1);
        #1;
        clear = 1'b1;
        #1;
        check("midrst_comp_async", comporta, 0);
        check("midrst_ocup_async", ocupado, 0);
        @(negedge clock);
        #1;
        sensor_presenca = 1'b0;
        clear = 1'b0;
        snap();
        step(1'b0, 2'b01, 20);
        check("midrst_no_extra_pulse", (n_pr - b_pr) + (n_pn - b_pn), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/classificador_residuos.md
# classificador_residuos

Item sorter FSM that sits directly upstream of the recyclable and non-recyclable item counters. It debounces the conveyor presence sensor and samples the material code once per item. It emits exactly one single-cycle count pulse per item to the matching counter and drives the diverter gate for a fixed time. It also flags a jammed item via a timeout.

## Interface
- `DEBOUNCE`, 4: consecutive high samples of `sensor_presenca` needed to accept an item (≥2).
- `GATE_CYCLES`, 8: cycles `comporta` is held after classification (≥1).
- `TIMEOUT`, 32: max cycles an item may remain present after the gate phase before `erro` (≥1).
- `clock`, in, 1: single system clock, rising edge.
- `clear`, in, 1: reset, asynchronous, active-high.
- `sensor_presenca`, in, 1: item present on belt (raw, may bounce).
- `sensor_material`, in, 2: material code. 00 unknown, 01 plastic, 10 metal, 11 organic.
- `pulso_reciclavel`, out, 1: one-cycle count pulse to the recyclable counter.
- `pulso_nao_reciclavel`, out, 1: one-cycle count pulse to the non-recyclable counter.
- `comporta`, out, 1: diverter gate. 1 routes the item to the recyclable bin, 0 to the non-recyclable bin.
- `ocupado`, out, 1: high in every state except IDLE.
- `erro`, out, 1: sticky jam flag.

## Operation
- **Reset:** all outputs are 0, state is IDLE, and internal counters are 0. Asserting `clear` mid-operation aborts immediately, with no pulse and no gate.
- **IDLE:** when `sensor_presenca` = 1, go to DETECT with the debounce count at 1.
- **DETECT:** while presence = 1, increment the count. When it reaches `DEBOUNCE`, go to CLASSIFY. If presence = 0 at any sample, return to IDLE with the count at 0 and no pulse.
- **CLASSIFY:** occupies one cycle. At its closing edge, sample `sensor_material`, then:
  - codes 01 and 10 are recyclable: set `pulso_reciclavel` and `comporta`;
  - codes 11 and 00 are non-recyclable (unknown defaults to non-recyclable): set `pulso_nao_reciclavel` and clear `comporta`;
  - go to ACTUATE.
  - Presence is ignored in CLASSIFY.
- **ACTUATE:** lasts `GATE_CYCLES` cycles. `comporta` is held stable and both pulses are 0. Then go to WAIT_CLEAR with the timeout count at 0.
- **WAIT_CLEAR:** `comporta` returns to 0 on entry.
  - presence = 0: go to IDLE;
  - otherwise increment the count; at `TIMEOUT` consecutive present cycles, set `erro` and go to ERRO.
- **ERRO:** terminal. `erro` = 1 and `ocupado` = 1. No pulses are emitted. Only `clear` exits.
- **Counting guarantees:**
  - exactly one pulse per accepted item;
  - the two pulses are never high simultaneously;
  - an item that stays present never produces a second pulse until presence has dropped and been re-debounced.

## Timing
- All outputs are registered; nothing combinational reaches a port.
- **Pulse latency:** presence rises before edge 1 and stays high.
  - DETECT is entered at edge 1; the debounce count reaches `DEBOUNCE` at edge `DEBOUNCE`, entering CLASSIFY.
  - The pulse is high in the cycle after edge `DEBOUNCE`+1, for exactly one cycle.
  - With defaults, the pulse is high between edges 5 and 6.
- `comporta` is valid in the same cycle as the pulse and stays for `GATE_CYCLES` cycles.
- **Minimum item period:** `DEBOUNCE` + 1 + `GATE_CYCLES` + 1 cycles. This includes one presence-low sample in WAIT_CLEAR.
- **Material sampling:**
  - The material code is sampled only at the CLASSIFY edge.
  - Changes to it at any other time have no effect.
- **Counter widths:** debounce, gate and timeout counters are sized by `$clog2` of their parameter plus 1. They saturate, never wrap.

## Structure
- Package `classificador_pkg` holds:
  - the state enum: IDLE, DETECT, CLASSIFY, ACTUATE, WAIT_CLEAR, ERRO;
  - material code constants: MAT_DESCONHECIDO, MAT_PLASTICO, MAT_METAL, MAT_ORGANICO;
  - the function `eh_reciclavel(code)`.
- Sub-module `contador_ciclos`:
  - a parameterised up-counter with `clear`, synchronous restart, enable and a `fim` flag;
  - instantiated for debounce, gate and timeout.
- The top level holds the FSM and output registers only.

## Test plan
All scenarios use default parameters.
- **Reset:** `clear` = 1 for 2 cycles with presence = 1 and material = 01 → all outputs 0 and no pulse. After release, the first pulse appears 5 edges later.
- **Plastic item:**
  - Presence high for 20 cycles, material = 01 → `pulso_reciclavel` high for exactly 1 cycle, between edges 5 and 6.
  - `comporta` = 1 for 8 cycles, `pulso_nao_reciclavel` never asserts, and `erro` stays 0.
- **Bounce rejection:** presence pattern 1,1,1,0,1,1,1,0 (high runs of 3 < `DEBOUNCE` = 4) → no pulse, and `ocupado` returns to 0 after each drop.
- **Organic then unknown:** two separated items with codes 11 then 00 → two `pulso_nao_reciclavel` pulses, `comporta` = 0 both times, and 0 recyclable pulses.
- **Jam:** presence held high for 60 cycles → one pulse only, then `erro` = 1 from the `TIMEOUT`-th WAIT_CLEAR cycle. `erro` stays 1 after presence drops, until `clear`.
- **Mid-operation reset:** `clear` asserted during ACTUATE → `comporta` and `ocupado` drop asynchronously, before the next clock edge, and no extra pulse follows release.
